// File: rtl/sprite_arb_pkg.sv
// -----------------------------------------------------------------------------
// sprite_arb_pkg
// Shared types and constants for the sprite ROM arbiter.
//   arb_state_t        : arbiter FSM state (IDLE / BURST)
//   KEY_COLOR_DEFAULT  : ROM colour treated as transparent
//   N_REQ_DEFAULT      : default requester count
//   rr_pick()          : behavioural round-robin pick for the default width
// -----------------------------------------------------------------------------
package sprite_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hFF0000;
    localparam int          N_REQ_DEFAULT     = 4;

    // One-hot pick of the first asserted request at or above ptr, wrapping.
    function automatic logic [N_REQ_DEFAULT-1:0] rr_pick(
        input logic [N_REQ_DEFAULT-1:0]         req,
        input logic [$clog2(N_REQ_DEFAULT)-1:0] ptr
    );
        logic [N_REQ_DEFAULT-1:0] pick;
        int                       idx;
        pick = '0;
        for (int k = 0; k < N_REQ_DEFAULT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ_DEFAULT) idx = idx - N_REQ_DEFAULT;
            if (req[idx] && (pick == '0)) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: rotate the request vector so that ptr
// sits at bit 0, take the lowest set bit, rotate the result back.
//   req  in  N      request vector
//   ptr  in  PTR_W  highest-priority index (must be < N)
//   pick out N      one-hot winner, 0 when no request
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_pick;

    function automatic int wrap(input int x);
        return (x >= N) ? x - N : x;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        rot      = '0;
        rot_pick = '0;
        pick     = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[wrap(int'(ptr) + i)];
        end
        // Scan high to low so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_pick    = '0;
                rot_pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            pick[wrap(int'(ptr) + i)] = rot_pick[i];
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one registered sprite ROM read port among N_REQ draw engines with
// round-robin arbitration and locked bursts of up to BURST_MAX beats.
//   Clk              in   system clock
//   Reset            in   synchronous active-high reset
//   req              in   N_REQ         per-requester read request
//   req_addr         in   N_REQ*ADDR_W  packed addresses, slot i at [i*ADDR_W +: ADDR_W]
//   req_last         in   N_REQ         beat ends the burst (1 = single read)
//   gnt              out  N_REQ         one-hot combinational grant
//   rom_addr         out  ADDR_W        ROM read address of the accepted beat
//   rom_data         in   24            ROM data, valid the cycle after rom_addr
//   rsp_valid        out  N_REQ         one-hot, one cycle after acceptance
//   rsp_data         out  24            ROM data, 0 for an out-of-range beat
//   rsp_transparent  out  1             key colour hit or out-of-range beat
// -----------------------------------------------------------------------------
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter int          ADDR_W    = 19,
    parameter int unsigned DEPTH     = 1024,
    parameter int          BURST_MAX = 32,
    parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [23:0]               rom_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [23:0]               rsp_data,
    output logic                      rsp_transparent
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  beat_cnt;
    logic              oor_q;

    logic [N_REQ-1:0]  rr_gnt;
    logic              accept;
    logic [PTR_W-1:0]  acc_idx;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_last;
    logic              acc_oor;
    logic              burst_end;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit compare keeps the wrap right for non-power-of-two N_REQ.
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_priority_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (rr_gnt)
    );

    always_comb begin
        gnt      = '0;
        acc_idx  = '0;
        acc_addr = '0;
        acc_last = 1'b0;
        if (!Reset) begin
            if (state == IDLE) begin
                gnt = rr_gnt;
            end else if (req[owner]) begin
                gnt[owner] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                acc_idx  = PTR_W'(i);
                acc_addr = req_addr[i*ADDR_W +: ADDR_W];
                acc_last = req_last[i];
            end
        end
    end

    // gnt only ever carries requesting bits, so any grant is an accepted beat.
    assign accept    = |(gnt & req);
    assign acc_oor   = accept && ({1'b0, acc_addr} >= (ADDR_W + 1)'(DEPTH));
    assign rom_addr  = (accept && !acc_oor) ? acc_addr : '0;
    assign burst_end = acc_last || (beat_cnt + CNT_W'(1) == CNT_W'(BURST_MAX));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            rsp_valid <= '0;
            oor_q     <= 1'b0;
        end else begin
            rsp_valid <= gnt & req;
            oor_q     <= acc_oor;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (acc_last || BURST_MAX == 1) begin
                            rr_ptr <= ptr_inc(acc_idx);
                        end else begin
                            owner    <= acc_idx;
                            beat_cnt <= CNT_W'(1);
                            state    <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        // Owner dropped its request: abort and re-arbitrate.
                        state    <= IDLE;
                        rr_ptr   <= ptr_inc(owner);
                        beat_cnt <= '0;
                    end else if (burst_end) begin
                        state    <= IDLE;
                        rr_ptr   <= ptr_inc(owner);
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_data        = oor_q ? 24'h0 : rom_data;
    assign rsp_transparent = oor_q | (rom_data == KEY_COLOR);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int          N     = 4;
    localparam int          AW    = 19;
    localparam int          DEPTH = 1024;
    localparam int          BMAX  = 32;
    localparam logic [23:0] KEY   = 24'hFF0000;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_last;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic [23:0]       rom_data;
    logic [N-1:0]      rsp_valid;
    logic [23:0]       rsp_data;
    logic              rsp_transparent;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .BURST_MAX (BMAX),
        .KEY_COLOR (KEY)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .req             (req),
        .req_addr        (req_addr),
        .req_last        (req_last),
        .gnt             (gnt),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_transparent (rsp_transparent)
    );

    // Sprite ROM stand-in: registered lookup, two fixed test colours.
    function automatic logic [23:0] rom_fn(input logic [AW-1:0] a);
        if (a == 5) return KEY;
        if (a == 6) return 24'h142608;
        return {4'h1, a[9:0], a[9:0]};
    endfunction

    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model state.
    int          m_ptr    = 0;
    int          m_owner  = 0;
    int          m_beats  = 0;
    bit          m_locked = 1'b0;
    logic [N-1:0] exp_v   = '0;
    logic [23:0] exp_data = '0;
    logic        exp_tr   = 1'b0;

    // Values sampled from the DUT in the most recent step.
    logic [N-1:0] obs_gnt, obs_rsp_valid;
    logic [AW-1:0] obs_rom_addr;
    logic [23:0]  obs_rsp_data;
    logic         obs_tr;

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // One clock cycle: drive inputs, check the previous cycle's response,
    // check this cycle's grant, then advance the model across the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input bit rst);
        logic [N-1:0]  eg;
        logic [AW-1:0] a;
        int            w;
        bit            oor;
        req = r; req_last = l; Reset = rst;
        #1;
        obs_rsp_valid = rsp_valid;
        obs_rsp_data  = rsp_data;
        obs_tr        = rsp_transparent;
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v != '0) begin
            check("rsp_data", rsp_data, exp_data);
            check("rsp_transparent", rsp_transparent, exp_tr);
        end
        eg = '0;
        w  = -1;
        if (!rst) begin
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    int idx = (m_ptr + k) % N;
                    if (r[idx] && w < 0) w = idx;
                end
            end else if (r[m_owner]) begin
                w = m_owner;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        a   = (w >= 0) ? req_addr[w*AW +: AW] : '0;
        oor = (w >= 0) && (a >= DEPTH);
        obs_gnt      = gnt;
        obs_rom_addr = rom_addr;
        check("gnt", gnt, eg);
        check("rom_addr", rom_addr, (oor || w < 0) ? 0 : a);
        exp_v    = eg;
        exp_data = oor ? 24'h0 : rom_fn(a);
        exp_tr   = oor || (rom_fn(a) == KEY);
        if (rst) begin
            m_locked = 1'b0; m_ptr = 0; m_beats = 0;
        end else if (!m_locked) begin
            if (w >= 0) begin
                if (l[w]) m_ptr = (w + 1) % N;
                else begin m_locked = 1'b1; m_owner = w; m_beats = 1; end
            end
        end else if (w >= 0) begin
            m_beats++;
            if (l[w] || m_beats == BMAX) begin m_locked = 1'b0; m_ptr = (w + 1) % N; end
        end else begin
            m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
        end
        @(negedge Clk);
    endtask

    initial begin
        int cnt_g, cnt_v;
        logic [N-1:0] r, l;
        bit rst;
        req = '0; req_last = '1; req_addr = '0; Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);

        // Reset state: no grant even with every requester asking.
        step(4'b1111, 4'b1111, 1'b1);
        check("reset_gnt", obs_gnt, 0);

        // Alternating single reads from requesters 1 and 3.
        for (int i = 0; i < 5; i++) begin
            step((i < 4) ? 4'b1010 : 4'b0000, 4'b1111, 1'b0);
            if (i < 4) check("t1_gnt", obs_gnt, (i % 2 == 0) ? 4'b0010 : 4'b1000);
            if (i > 0) check("t1_rsp", obs_rsp_valid, (i % 2 == 1) ? 4'b0010 : 4'b1000);
        end

        // Full-length burst from requester 2 against contention.
        step(4'b0010, 4'b1111, 1'b0);
        cnt_g = 0; cnt_v = 0;
        for (int b = 0; b < 32; b++) begin
            set_addr(2, AW'(b));
            set_addr(0, AW'($urandom_range(0, 1023)));
            set_addr(3, AW'($urandom_range(0, 1023)));
            step(4'b1111, 4'b1011, 1'b0);
            if (obs_gnt == 4'b0100) cnt_g++;
            if (obs_rsp_valid == 4'b0100) cnt_v++;
        end
        step(4'b1111, 4'b1111, 1'b0);
        if (obs_rsp_valid == 4'b0100) cnt_v++;
        check("t2_release_gnt", obs_gnt, 4'b1000);
        check("t2_burst_gnts", cnt_g, 32);
        check("t2_rsp_pulses", cnt_v, 32);

        // Requester 1 ends its burst itself on beat 5.
        cnt_g = 0;
        for (int b = 0; b < 5; b++) begin
            set_addr(1, AW'(100 + b));
            step(4'b0110, (b == 4) ? 4'b1111 : 4'b1101, 1'b0);
            if (obs_gnt == 4'b0010) cnt_g++;
        end
        check("t3_grants", cnt_g, 5);
        step(4'b0110, 4'b1111, 1'b0);
        check("t3_next", obs_gnt, 4'b0100);

        // Requester 0 aborts its burst on beat 3.
        step(4'b0001, 4'b1110, 1'b0);
        step(4'b1111, 4'b1110, 1'b0);
        check("t4_beat2", obs_gnt, 4'b0001);
        step(4'b1110, 4'b1111, 1'b0);
        check("t4_abort_gnt", obs_gnt, 4'b0000);
        step(4'b1111, 4'b1111, 1'b0);
        check("t4_rearb", obs_gnt, 4'b0010);

        // Out-of-range read and the two key-colour cases.
        set_addr(3, AW'(1024));
        step(4'b1000, 4'b1111, 1'b0);
        check("t5_oor_addr", obs_rom_addr, 0);
        set_addr(3, AW'(5));
        step(4'b1000, 4'b1111, 1'b0);
        check("t5_oor_data", obs_rsp_data, 0);
        check("t5_oor_transp", obs_tr, 1);
        set_addr(3, AW'(6));
        step(4'b1000, 4'b1111, 1'b0);
        check("t5_key_data", obs_rsp_data, 24'hFF0000);
        check("t5_key_transp", obs_tr, 1);
        step(4'b0000, 4'b1111, 1'b0);
        check("t5_opaque_data", obs_rsp_data, 24'h142608);
        check("t5_opaque_transp", obs_tr, 0);

        // Reset in the middle of a burst from requester 2.
        set_addr(2, AW'(200));
        step(4'b0100, 4'b1011, 1'b0);
        step(4'b0100, 4'b1011, 1'b0);
        step(4'b1111, 4'b1011, 1'b1);
        check("t6_reset_gnt", obs_gnt, 0);
        step(4'b1111, 4'b1111, 1'b0);
        check("t6_rsp_after_reset", obs_rsp_valid, 0);
        check("t6_first_gnt", obs_gnt, 4'b0001);

        // Randomized traffic, occasional reset.
        for (int c = 0; c < 800; c++) begin
            r = N'($urandom);
            for (int i = 0; i < N; i++) begin
                l[i] = ($urandom_range(0, 7) == 0);
                set_addr(i, AW'($urandom_range(0, 1100)));
            end
            rst = ($urandom_range(0, 99) == 0);
            step(r, l, rst);
        end
        step(4'b0000, 4'b1111, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
